// File: rtl/bram_port_arbiter_if.sv
// Requester and RAM-port bundles for the shared block-RAM arbiter.
// Member names are seen from the arbiter: _in is driven into it.
interface bram_port_arbiter_if #(
   parameter int ADDR_WIDTH = 10,
   parameter int NB_COL     = 4,
   parameter int COL_WIDTH  = 8
);
   logic                          valid_in;
   logic                          ready_out;
   logic [ADDR_WIDTH-1:0]         addr_in;
   logic [NB_COL*COL_WIDTH-1:0]   wdata_in;
   logic [NB_COL-1:0]             wstrb_in;
   logic                          rvalid_out;
   logic [NB_COL*COL_WIDTH-1:0]   rdata_out;

   modport master (
      output valid_in, addr_in, wdata_in, wstrb_in,
      input  ready_out, rvalid_out, rdata_out
   );

   modport slave (
      input  valid_in, addr_in, wdata_in, wstrb_in,
      output ready_out, rvalid_out, rdata_out
   );
endinterface

interface bram_port_if #(
   parameter int ADDR_WIDTH = 10,
   parameter int NB_COL     = 4,
   parameter int COL_WIDTH  = 8
);
   logic [ADDR_WIDTH-1:0]         addr_out;
   logic [NB_COL*COL_WIDTH-1:0]   din_out;
   logic [NB_COL-1:0]             we_out;
   logic                          en_out;
   logic                          regce_out;
   logic                          rst_out;
   logic [NB_COL*COL_WIDTH-1:0]   dout_in;

   modport master (
      output addr_out, din_out, we_out, en_out, regce_out, rst_out,
      input  dout_in
   );

   modport slave (
      input  addr_out, din_out, we_out, en_out, regce_out, rst_out,
      output dout_in
   );
endinterface

// File: rtl/bram_port_arbiter.sv
// Round-robin arbiter sharing one block-RAM port between two requesters.
// A tag pipeline matched to the RAM latency routes each response home.
module bram_port_arbiter #(
   parameter int ADDR_WIDTH   = 10,
   parameter int NB_COL       = 4,
   parameter int COL_WIDTH    = 8,
   parameter int READ_LATENCY = 2
) (
   input  logic               clk_in,
   input  logic               rst_in,
   bram_port_arbiter_if.slave m0,
   bram_port_arbiter_if.slave m1,
   bram_port_if.master        bram
);
   if (READ_LATENCY < 1 || READ_LATENCY > 2) begin : g_bad_latency
      $error("READ_LATENCY must be 1 or 2");
   end

   logic gnt0, gnt1, xfer;
   logic last_q, last_d;
   logic [READ_LATENCY-1:0] tv_q, tv_d;
   logic [READ_LATENCY-1:0] tid_q, tid_d;
   logic [ADDR_WIDTH-1:0] addr_sel;
   logic [NB_COL*COL_WIDTH-1:0] din_sel;
   logic [NB_COL-1:0] we_sel;

   // last_q=1 means m1 was granted most recently
   always_comb begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
      if (!rst_in) begin
         case ({m0.valid_in, m1.valid_in})
            2'b10: gnt0 = 1'b1;
            2'b01: gnt1 = 1'b1;
            2'b11: begin
               gnt0 = last_q;
               gnt1 = !last_q;
            end
            default: ;
         endcase
      end
   end

   assign xfer   = gnt0 | gnt1;
   assign last_d = xfer ? gnt1 : last_q;

   always_comb begin
      tv_d     = tv_q;
      tid_d    = tid_q;
      tv_d[0]  = xfer;
      tid_d[0] = gnt1;
      for (int k = 1; k < READ_LATENCY; k++) begin
         tv_d[k]  = tv_q[k-1];
         tid_d[k] = tid_q[k-1];
      end
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         last_q <= 1'b1;
         tv_q   <= '0;
         tid_q  <= '0;
      end else begin
         last_q <= last_d;
         tv_q   <= tv_d;
         tid_q  <= tid_d;
      end
   end

   // Idle cycles still present m0's address/data; only en/we matter
   always_comb begin
      addr_sel = m0.addr_in;
      din_sel  = m0.wdata_in;
      we_sel   = {NB_COL{1'b0}};
      if (gnt1) begin
         addr_sel = m1.addr_in;
         din_sel  = m1.wdata_in;
         we_sel   = m1.wstrb_in;
      end else if (gnt0) begin
         we_sel   = m0.wstrb_in;
      end
   end

   assign bram.addr_out  = addr_sel;
   assign bram.din_out   = din_sel;
   assign bram.we_out    = we_sel;
   assign bram.en_out    = xfer;
   assign bram.regce_out = (READ_LATENCY == 2) ? tv_q[0] : 1'b0;
   assign bram.rst_out   = rst_in;

   assign m0.ready_out  = gnt0;
   assign m1.ready_out  = gnt1;
   assign m0.rvalid_out = tv_q[READ_LATENCY-1] && !tid_q[READ_LATENCY-1];
   assign m1.rvalid_out = tv_q[READ_LATENCY-1] && tid_q[READ_LATENCY-1];
   assign m0.rdata_out  = bram.dout_in;
   assign m1.rdata_out  = bram.dout_in;
endmodule

// File: tb/tb_bram_port_arbiter.sv
// Bench for bram_port_arbiter: directed scenarios plus random traffic
// checked against a queue-based transaction model of the shared port.
module tb_bram_port_arbiter;
   localparam int AW  = 10;
   localparam int NB  = 4;
   localparam int CW  = 8;
   localparam int DW  = NB * CW;
   localparam int LAT = 2;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst;
   logic pre;

   bram_port_arbiter_if #(.ADDR_WIDTH(AW), .NB_COL(NB), .COL_WIDTH(CW)) m0 ();
   bram_port_arbiter_if #(.ADDR_WIDTH(AW), .NB_COL(NB), .COL_WIDTH(CW)) m1 ();
   bram_port_arbiter_if #(.ADDR_WIDTH(AW), .NB_COL(NB), .COL_WIDTH(CW)) n0 ();
   bram_port_arbiter_if #(.ADDR_WIDTH(AW), .NB_COL(NB), .COL_WIDTH(CW)) n1 ();
   bram_port_if #(.ADDR_WIDTH(AW), .NB_COL(NB), .COL_WIDTH(CW)) b2 ();
   bram_port_if #(.ADDR_WIDTH(AW), .NB_COL(NB), .COL_WIDTH(CW)) b1 ();

   bram_port_arbiter #(
      .ADDR_WIDTH(AW), .NB_COL(NB), .COL_WIDTH(CW), .READ_LATENCY(2)
   ) dut (
      .clk_in(clk), .rst_in(rst), .m0(m0), .m1(m1), .bram(b2)
   );

   bram_port_arbiter #(
      .ADDR_WIDTH(AW), .NB_COL(NB), .COL_WIDTH(CW), .READ_LATENCY(1)
   ) dut1 (
      .clk_in(clk), .rst_in(rst), .m0(n0), .m1(n1), .bram(b1)
   );

   function automatic logic [DW-1:0] initw(int i);
      if (i == 5) return 32'hDEADBEEF;
      if (i == 3) return 32'hAABBCCDD;
      return 32'h5A00_0000 ^ (32'(i) * 32'h0100_0193);
   endfunction

   // Read-first byte-write RAMs: registered output for LAT=2, plain for LAT=1
   logic [DW-1:0] mem2 [1024];
   logic [DW-1:0] mem1 [1024];
   logic [DW-1:0] lat2, reg2, lat1;

   always @(posedge clk) begin
      if (pre) begin
         for (int i = 0; i < 1024; i++) begin
            mem2[i] <= initw(i);
            mem1[i] <= initw(i);
         end
      end else begin
         if (b2.en_out) begin
            lat2 <= mem2[b2.addr_out];
            for (int j = 0; j < NB; j++)
               if (b2.we_out[j])
                  mem2[b2.addr_out][j*CW +: CW] <= b2.din_out[j*CW +: CW];
         end
         if (b1.en_out) begin
            lat1 <= mem1[b1.addr_out];
            for (int j = 0; j < NB; j++)
               if (b1.we_out[j])
                  mem1[b1.addr_out][j*CW +: CW] <= b1.din_out[j*CW +: CW];
         end
      end
      if (b2.rst_out) reg2 <= '0;
      else if (b2.regce_out) reg2 <= lat2;
   end

   assign b2.dout_in = reg2;
   assign b1.dout_in = lat1;

   typedef struct {
      int            due;
      bit            id;
      logic [DW-1:0] data;
   } rsp_t;

   rsp_t          q[$];
   logic [DW-1:0] sh [1024];
   bit            m_last;
   bit            acc0, acc1;
   int            cyc;
   int            pass_n;
   int            total_n;
   int            fail_n;

   task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
      total_n++;
      assert (obs === exp) pass_n++;
      else begin
         fail_n++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic drv0(bit v, int a, logic [DW-1:0] d, logic [NB-1:0] s);
      m0.valid_in = v;
      m0.addr_in  = AW'(a);
      m0.wdata_in = d;
      m0.wstrb_in = s;
   endtask

   task automatic drv1(bit v, int a, logic [DW-1:0] d, logic [NB-1:0] s);
      m1.valid_in = v;
      m1.addr_in  = AW'(a);
      m1.wdata_in = d;
      m1.wstrb_in = s;
   endtask

   // One clock: check the port against the model, then commit the model
   task automatic step();
      bit            e0, e1, x0, x1, xr, hit;
      logic [DW-1:0] xd, w;
      logic [NB-1:0] s;
      int            a;
      rsp_t          r;
      @(negedge clk);
      e0 = 1'b0;
      e1 = 1'b0;
      if (!rst) begin
         if (m0.valid_in && m1.valid_in) begin
            e0 = m_last;
            e1 = !m_last;
         end else begin
            e0 = m0.valid_in;
            e1 = m1.valid_in;
         end
      end
      chk("m0_ready", 64'(m0.ready_out), 64'(e0));
      chk("m1_ready", 64'(m1.ready_out), 64'(e1));
      chk("bram_en", 64'(b2.en_out), 64'(e0 | e1));
      chk("bram_we", 64'(b2.we_out),
          64'(e0 ? m0.wstrb_in : e1 ? m1.wstrb_in : 4'b0));
      chk("bram_addr", 64'(b2.addr_out),
          64'(e1 ? m1.addr_in : m0.addr_in));
      chk("bram_din", 64'(b2.din_out),
          64'(e1 ? m1.wdata_in : m0.wdata_in));
      chk("bram_rst", 64'(b2.rst_out), 64'(rst));
      hit = (q.size() > 0) && (q[0].due == cyc);
      if (!rst) begin
         x0 = hit && !q[0].id;
         x1 = hit && q[0].id;
         xd = hit ? q[0].data : '0;
         chk("m0_rvalid", 64'(m0.rvalid_out), 64'(x0));
         chk("m1_rvalid", 64'(m1.rvalid_out), 64'(x1));
         if (hit)
            chk("rdata", 64'(x0 ? m0.rdata_out : m1.rdata_out), 64'(xd));
         xr = 1'b0;
         foreach (q[i]) if (q[i].due == cyc + 1) xr = 1'b1;
         chk("regce", 64'(b2.regce_out), 64'(xr));
      end
      if (hit) void'(q.pop_front());
      if (e0 | e1) begin
         a = e1 ? int'(m1.addr_in) : int'(m0.addr_in);
         w = e1 ? m1.wdata_in : m0.wdata_in;
         s = e1 ? m1.wstrb_in : m0.wstrb_in;
         r.due  = cyc + LAT;
         r.id   = e1;
         r.data = sh[a];
         for (int j = 0; j < NB; j++)
            if (s[j]) sh[a][j*CW +: CW] = w[j*CW +: CW];
         q.push_back(r);
         m_last = e1;
      end
      if (rst) begin
         q.delete();
         m_last = 1'b1;
      end
      acc0 = e0;
      acc1 = e1;
      @(posedge clk);
      #1;
      cyc++;
   endtask

   initial begin
      pass_n  = 0;
      total_n = 0;
      fail_n  = 0;
      cyc     = 0;
      m_last  = 1'b1;
      acc0    = 1'b0;
      acc1    = 1'b0;
      rst     = 1'b1;
      pre     = 1'b1;
      for (int i = 0; i < 1024; i++) sh[i] = initw(i);
      drv0(0, 0, '0, '0);
      drv1(0, 0, '0, '0);
      n0.valid_in = 1'b0; n0.addr_in = '0; n0.wdata_in = '0; n0.wstrb_in = '0;
      n1.valid_in = 1'b0; n1.addr_in = '0; n1.wdata_in = '0; n1.wstrb_in = '0;
      step();
      pre = 1'b0;
      step();
      step();
      rst = 1'b0;
      step();
      step();

      // single read
      drv0(1, 5, '0, '0);
      step();
      drv0(0, 5, '0, '0);
      repeat (3) step();

      // byte write then read back (leaves m1 as last grant)
      drv1(1, 3, 32'h11223344, 4'b0101);
      step();
      drv1(1, 3, '0, '0);
      step();
      drv1(0, 3, '0, '0);
      repeat (3) step();

      // contention
      drv0(1, 7, '0, '0);
      drv1(1, 8, '0, '0);
      repeat (6) step();
      drv0(0, 0, '0, '0);
      drv1(0, 0, '0, '0);
      repeat (3) step();

      // back-to-back reads
      for (int i = 0; i < 16; i++) begin
         drv0(1, i, '0, '0);
         step();
      end
      drv0(0, 0, '0, '0);
      repeat (3) step();

      // reset mid-flight, then tie after release
      drv0(1, 1, '0, '0);
      step();
      drv0(1, 2, '0, '0);
      step();
      drv0(0, 0, '0, '0);
      rst = 1'b1;
      step();
      rst = 1'b0;
      repeat (3) step();
      drv0(1, 9, '0, '0);
      drv1(1, 10, '0, '0);
      step();
      drv0(0, 0, '0, '0);
      drv1(0, 0, '0, '0);
      repeat (3) step();

      // random traffic, holding requests until accepted
      repeat (400) begin
         if (!(m0.valid_in && !acc0))
            drv0($urandom_range(0, 99) < 60, $urandom_range(0, 15), $urandom,
                 ($urandom_range(0, 3) == 0) ? 4'($urandom_range(1, 15)) : 4'b0);
         if (!(m1.valid_in && !acc1))
            drv1($urandom_range(0, 99) < 60, $urandom_range(0, 15), $urandom,
                 ($urandom_range(0, 3) == 0) ? 4'($urandom_range(1, 15)) : 4'b0);
         step();
      end
      drv0(0, 0, '0, '0);
      drv1(0, 0, '0, '0);
      repeat (4) step();

      // single-cycle-latency variant
      n0.valid_in = 1'b1;
      n0.addr_in  = AW'(5);
      @(negedge clk);
      chk("rl1_ready", 64'(n0.ready_out), 64'(1'b1));
      chk("rl1_en", 64'(b1.en_out), 64'(1'b1));
      chk("rl1_regce", 64'(b1.regce_out), 64'(1'b0));
      @(posedge clk);
      #1;
      n0.valid_in = 1'b0;
      @(negedge clk);
      chk("rl1_m0_rvalid", 64'(n0.rvalid_out), 64'(1'b1));
      chk("rl1_m1_rvalid", 64'(n1.rvalid_out), 64'(1'b0));
      chk("rl1_rdata", 64'(n0.rdata_out), 64'(32'hDEADBEEF));
      chk("rl1_regce_hold", 64'(b1.regce_out), 64'(1'b0));
      @(posedge clk);
      #1;
      @(negedge clk);
      chk("rl1_rvalid_done", 64'(n0.rvalid_out), 64'(1'b0));

      $display("%0d/%0d checks passed", pass_n, total_n);
      $finish;
   end
endmodule
